bubble_sort_ctrl: RTL and testbench

- Sequencer that sorts the contents of the single-port sorting RAM in place, in ascending unsigned order, using bubble sort with early exit.
- Sits directly upstream of the RAM and owns its we/addr/din; consumes the RAM's combinational read data (dout follows addr in the same cycle).
- Started by a one-cycle start pulse; reports busy, a one-cycle done pulse and the number of swaps performed.

---
 rtl/bubble_sort_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bubble_sort_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_sort_ctrl.sv
//==============================================================================
// Module   : bubble_sort_ctrl
// Brief    : In-place ascending bubble sort of a single-port RAM, early exit.
// Revision : 1.0
//==============================================================================
`default_nettype none

module bubble_sort_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int N          = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  swap_count
);

    // One spare bit so j+1 never aliases when N fills the whole address space
    localparam int IW = ADDR_WIDTH + 1;

    localparam logic [IW-1:0] c_N       = IW'(N);
    localparam logic [IW-1:0] c_LAST    = c_N - IW'(1);
    localparam logic          c_TRIVIAL = (N < 2);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RD_A  = 3'd1;
    localparam logic [2:0] c_RD_B  = 3'd2;
    localparam logic [2:0] c_CMP   = 3'd3;
    localparam logic [2:0] c_WR_HI = 3'd4;
    localparam logic [2:0] c_WR_LO = 3'd5;
    localparam logic [2:0] c_NEXT  = 3'd6;
    localparam logic [2:0] c_DONE  = 3'd7;

    logic [2:0]            state_q, state_d;
    logic [IW-1:0]         i_q, i_d;
    logic [IW-1:0]         j_q, j_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  swapped_q, swapped_d;
    logic [CNT_WIDTH-1:0]  swap_count_q, swap_count_d;

    logic [IW-1:0]         w_j1;
    logic [ADDR_WIDTH-1:0] w_addr_j;
    logic [ADDR_WIDTH-1:0] w_addr_j1;

    assign w_j1      = j_q + IW'(1);
    assign w_addr_j  = j_q[ADDR_WIDTH-1:0];
    assign w_addr_j1 = w_j1[ADDR_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        a_d          = a_q;
        b_d          = b_q;
        swapped_d    = swapped_q;
        swap_count_d = swap_count_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    swap_count_d = '0;
                    i_d          = '0;
                    j_d          = '0;
                    swapped_d    = 1'b0;
                    state_d      = c_TRIVIAL ? c_DONE : c_RD_A;
                end
            end
            c_RD_A: begin
                a_d     = ram_dout;
                state_d = c_RD_B;
            end
            c_RD_B: begin
                b_d     = ram_dout;
                state_d = c_CMP;
            end
            c_CMP: begin
                if (a_q > b_q) begin
                    swap_count_d = swap_count_q + CNT_WIDTH'(1);
                    swapped_d    = 1'b1;
                    state_d      = c_WR_HI;
                end else begin
                    state_d = c_NEXT;
                end
            end
            c_WR_HI: state_d = c_WR_LO;
            c_WR_LO: state_d = c_NEXT;
            c_NEXT: begin
                if (w_j1 < (c_LAST - i_q)) begin
                    j_d     = w_j1;
                    state_d = c_RD_A;
                end else if (!swapped_q || ((i_q + IW'(1)) == c_LAST)) begin
                    state_d = c_DONE;
                end else begin
                    i_d       = i_q + IW'(1);
                    j_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = c_RD_A;
                end
            end
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= c_IDLE;
            i_q          <= '0;
            j_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            swapped_q    <= 1'b0;
            swap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            a_q          <= a_d;
            b_q          <= b_d;
            swapped_q    <= swapped_d;
            swap_count_q <= swap_count_d;
        end
    end

    // RAM controls decode from registered state only, so reset kills ram_we at once
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state_q)
            c_RD_A:  ram_addr = w_addr_j;
            c_RD_B:  ram_addr = w_addr_j1;
            c_CMP:   ram_addr = w_addr_j1;
            c_WR_HI: begin
                ram_addr = w_addr_j1;
                ram_din  = a_q;
                ram_we   = 1'b1;
            end
            c_WR_LO: begin
                ram_addr = w_addr_j;
                ram_din  = b_q;
                ram_we   = 1'b1;
            end
            c_NEXT:  ram_addr = w_addr_j;
            default: ram_addr = '0;
        endcase
    end

    assign busy       = (state_q != c_IDLE) && (state_q != c_DONE);
    assign done       = (state_q == c_DONE);
    assign swap_count = swap_count_q;

endmodule

`default_nettype wire

// File: tb/tb_bubble_sort_ctrl.sv
//==============================================================================
// Module   : tb_bubble_sort_ctrl
// Brief    : Self-checking bench for bubble_sort_ctrl with a behavioural RAM.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_bubble_sort_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NN = 8;
    localparam int CW = 16;

    typedef byte unsigned arr_t [NN];
    typedef struct {
        arr_t d;
        arr_t e;
        int   sw;
        int   poke;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;
    logic          done;
    logic [CW-1:0] swap_count;

    logic          start1;
    logic          ram_we1;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] ram_din1;
    logic [DW-1:0] ram_dout1;
    logic          busy1;
    logic          done1;
    logic [CW-1:0] swap_count1;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
    end
    assign ram_dout  = mem[ram_addr];
    assign ram_dout1 = '0;

    bubble_sort_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N(NN), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy), .done(done),
        .swap_count(swap_count)
    );

    bubble_sort_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N(1), .CNT_WIDTH(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_din(ram_din1), .ram_dout(ram_dout1), .busy(busy1), .done(done1),
        .swap_count(swap_count1)
    );

    int n1_access = 0;
    always @(posedge clk) if (ram_we1 === 1'b1 || busy1 === 1'b1) n1_access++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input arr_t a);
        logic [63:0] r;
        for (int k = 0; k < NN; k++) r[8*k +: 8] = a[k];
        return r;
    endfunction

    function automatic logic [63:0] ram_image();
        logic [63:0] r;
        for (int k = 0; k < NN; k++) r[8*k +: 8] = mem[k];
        return r;
    endfunction

    // Reference: textbook bubble sort with early exit; timing from compare/swap counts
    task automatic model(input arr_t a, output arr_t s, output int sw, output int cyc);
        int  cmp;
        bit  any;
        byte unsigned t;
        s = a; sw = 0; cmp = 0;
        for (int p = 0; p < NN - 1; p++) begin
            any = 1'b0;
            for (int j = 0; j < NN - 1 - p; j++) begin
                cmp++;
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                    sw++; any = 1'b1;
                end
            end
            if (!any) break;
        end
        cyc = 4 * cmp + 2 * sw;
    endtask

    task automatic load_ram(input arr_t a);
        for (int k = 0; k < NN; k++) begin
            load_en = 1'b1; load_addr = AW'(k); load_data = a[k];
            @(posedge clk); #1;
        end
        load_en = 1'b0;
    endtask

    task automatic run_sort(input string tag, input arr_t a, input arr_t e, input int exp_sw,
                            input int busy_poke, input bit done_poke);
        arr_t s;
        int   msw, mcyc, cyc, wr;
        bit   busy_ok;
        load_ram(a);
        model(a, s, msw, mcyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 0; wr = 0; busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 2000) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (ram_we === 1'b1) wr++;
            start = (cyc == busy_poke);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, " done latency"}, 64'(cyc), 64'(mcyc));
        check({tag, " busy while sorting"}, 64'(busy_ok), 64'd1);
        check({tag, " busy in DONE"}, 64'(busy), 64'd0);
        check({tag, " write count"}, 64'(wr), 64'(2 * exp_sw));
        check({tag, " swap_count"}, 64'(swap_count), 64'(exp_sw));
        if (done_poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done one cycle"}, 64'(done), 64'd0);
        check({tag, " idle after done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, " swap_count held"}, 64'(swap_count), 64'(exp_sw));
        check({tag, " ram result"}, ram_image(), pack(e));
    endtask

    vec_t tbl [5];

    initial begin
        arr_t r, s;
        int   msw, mcyc, cyc;

        tbl[0].d = '{90, 25, 60, 15, 30, 75, 45, 10};
        tbl[0].e = '{10, 15, 25, 30, 45, 60, 75, 90}; tbl[0].sw = 18; tbl[0].poke = 5;
        tbl[1].d = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[1].e = '{1, 2, 3, 4, 5, 6, 7, 8};         tbl[1].sw = 0;  tbl[1].poke = 3;
        tbl[2].d = '{8, 7, 6, 5, 4, 3, 2, 1};
        tbl[2].e = '{1, 2, 3, 4, 5, 6, 7, 8};         tbl[2].sw = 28; tbl[2].poke = -1;
        tbl[3].d = '{5, 5, 5, 5, 5, 5, 5, 5};
        tbl[3].e = '{5, 5, 5, 5, 5, 5, 5, 5};         tbl[3].sw = 0;  tbl[3].poke = -1;
        tbl[4].d = '{3, 3, 1, 7, 7, 0, 9, 9};
        tbl[4].e = '{0, 1, 3, 3, 7, 7, 9, 9};         tbl[4].sw = 7;  tbl[4].poke = 10;

        rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        #3;
        check("reset ram_we", 64'(ram_we), 64'd0);
        check("reset ram_addr", 64'(ram_addr), 64'd0);
        check("reset ram_din", 64'(ram_din), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset swap_count", 64'(swap_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Sorted input must finish in 28 edges after start: 7 compares x 4 cycles
        load_ram(tbl[1].d);
        start = 1'b1; @(posedge clk); #1; start = 1'b0; cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        check("sorted fixed latency", 64'(cyc), 64'd28);
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++)
            run_sort($sformatf("vec%0d", v), tbl[v].d, tbl[v].e, tbl[v].sw, tbl[v].poke, v < 2);

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < NN; k++) r[k] = 8'($urandom_range(0, 31));
            model(r, s, msw, mcyc);
            run_sort($sformatf("rand%0d", t), r, s, msw, -1, 1'b0);
        end

        // Reset while the first swap's WR_HI is on the bus
        load_ram(tbl[0].d);
        start = 1'b1; @(posedge clk); #1; start = 1'b0; cyc = 0;
        while (ram_we !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("rst reached WR_HI", 64'(ram_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst ram_we drop", 64'(ram_we), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst swap_count", 64'(swap_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst still idle", 64'(busy), 64'd0);
        check("rst ram untouched", ram_image(), pack(tbl[0].d));
        run_sort("after reset", tbl[0].d, tbl[0].e, tbl[0].sw, -1, 1'b0);

        n1_access = 0;
        start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
        check("N1 done next cycle", 64'(done1), 64'd1);
        check("N1 busy in done", 64'(busy1), 64'd0);
        @(posedge clk); #1;
        check("N1 done pulse", 64'(done1), 64'd0);
        check("N1 no ram access", 64'(n1_access), 64'd0);
        check("N1 ram_addr", 64'(ram_addr1), 64'd0);
        check("N1 swap_count", 64'(swap_count1), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
